// File: rtl/core_interrupt_controller.sv
// core_interrupt_controller
// Interrupt entry/exit sequencing for the PIC16F core around INTCON.
// Detects RB0/INT edges, RB7:4 changes (optional) and TMR0 overflow, drives
// the INTCON flag-set strobes, and sequences stack push / PC vector load.
//
// Optional feature macro: CORE_INT_RB_CHANGE_EN (RB7:4 change detection).
//
// Ports:
//   clk, rst              core clock, synchronous active-high reset
//   intcon_*  (in)        INTCON enable and flag bits
//   tmr0_overflow         one-cycle TMR0 wrap pulse
//   rb0_pin, rb_port_hi   asynchronous PORTB pins
//   option_intedg         RB0/INT edge select (1 = rising)
//   rb_port_read          core read of PORTB
//   instr_boundary        instruction finished, next fetch not committed
//   retfie_exec           RETFIE executing
//   intcon_*_en (out)     GIE clear/set and flag-set strobes to INTCON
//   int_stack_push        push PC onto hardware stack
//   int_pc_load           load PC from int_vector
//   int_vector            constant interrupt vector
//   int_busy              interrupt entry in progress, fetch stalled
//   sleep_wake            any enabled flag set, independent of GIE
module core_interrupt_controller #(
  parameter int unsigned          PC_WIDTH    = 13,
  parameter logic [PC_WIDTH-1:0]  VECTOR_ADDR = PC_WIDTH'(4)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                intcon_gie,
  input  logic                intcon_peie,
  input  logic                intcon_t0ie,
  input  logic                intcon_inte,
  input  logic                intcon_rbie,
  input  logic                intcon_t0if,
  input  logic                intcon_intf,
  input  logic                intcon_rbif,
  input  logic                tmr0_overflow,
  input  logic                rb0_pin,
  input  logic                option_intedg,
  input  logic [3:0]          rb_port_hi,
  input  logic                rb_port_read,
  input  logic                instr_boundary,
  input  logic                retfie_exec,
  output logic                intcon_gie_clr_en,
  output logic                intcon_gie_set_en,
  output logic                intcon_t0if_set_en,
  output logic                intcon_intf_set_en,
  output logic                intcon_rbif_set_en,
  output logic                int_stack_push,
  output logic                int_pc_load,
  output logic [PC_WIDTH-1:0] int_vector,
  output logic                int_busy,
  output logic                sleep_wake
);

  typedef enum logic [1:0] {IDLE, PENDING, PUSH, VECTOR} state_t;

  state_t     state, state_next;
  logic [2:0] rb0_sync;      // [0],[1] synchroniser stages, [2] edge history
  logic       intf_edge_q;
  logic       rb_mismatch;
  logic       rb_term;
  logic       source_active;
  logic       pending;

  // RB0/INT synchroniser, edge history and registered edge strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rb0_sync    <= '0;
      intf_edge_q <= 1'b0;
    end else begin
      rb0_sync    <= {rb0_sync[1:0], rb0_pin};
      intf_edge_q <= option_intedg ? (rb0_sync[1] & ~rb0_sync[2])
                                   : (~rb0_sync[1] & rb0_sync[2]);
    end
  end

`ifdef CORE_INT_RB_CHANGE_EN
  logic [3:0] rb_sync1, rb_sync2, rb_latch;
  logic       unused_inputs;

  // RB7:4 synchroniser and last-read latch
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_sync1 <= '0;
      rb_sync2 <= '0;
      rb_latch <= '0;
    end else begin
      rb_sync1 <= rb_port_hi;
      rb_sync2 <= rb_sync1;
      if (rb_port_read) rb_latch <= rb_sync2;
    end
  end

  assign rb_mismatch   = (rb_sync2 != rb_latch);
  assign rb_term       = intcon_rbie & intcon_rbif;
  assign unused_inputs = intcon_peie;
`else
  logic unused_inputs;

  assign rb_mismatch   = 1'b0;
  assign rb_term       = 1'b0;
  assign unused_inputs = ^{intcon_peie, rb_port_hi, rb_port_read,
                           intcon_rbie, intcon_rbif};
`endif

  assign source_active = (intcon_t0ie & intcon_t0if) |
                         (intcon_inte & intcon_intf) | rb_term;
  assign pending       = intcon_gie & source_active;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and strobes; everything held quiet while rst is asserted
  always_comb begin
    state_next         = state;
    int_stack_push     = 1'b0;
    intcon_gie_clr_en  = 1'b0;
    int_pc_load        = 1'b0;
    int_busy           = 1'b0;
    intcon_gie_set_en  = !rst && retfie_exec;
    intcon_t0if_set_en = !rst && tmr0_overflow;
    intcon_intf_set_en = !rst && intf_edge_q;
    intcon_rbif_set_en = !rst && rb_mismatch;
    sleep_wake         = !rst && source_active;
    case (state)
      IDLE: begin
        if (pending) state_next = PENDING;
      end
      PENDING: begin
        int_busy = !rst;
        // Software withdrawing the request wins over a coincident boundary
        if (!pending)           state_next = IDLE;
        else if (instr_boundary) state_next = PUSH;
      end
      PUSH: begin
        int_busy          = !rst;
        int_stack_push    = !rst;
        intcon_gie_clr_en = !rst;
        state_next        = VECTOR;
      end
      VECTOR: begin
        int_busy    = !rst;
        int_pc_load = !rst;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign int_vector = VECTOR_ADDR;

endmodule

// File: tb/tb_core_interrupt_controller.sv
// Self-checking bench for core_interrupt_controller: directed entry/exit
// sequences followed by randomized event streams against a history model.
module tb_core_interrupt_controller;

  localparam int unsigned PC_WIDTH = 13;
  localparam int unsigned NRAND    = 200;

  logic clk = 1'b0;
  logic rst;
  logic gie, peie, t0ie, inte, rbie, t0if, intf, rbif;
  logic tmr0_overflow, rb0_pin, option_intedg, rb_port_read;
  logic instr_boundary, retfie_exec;
  logic [3:0] rb_port_hi;
  logic gie_clr_en, gie_set_en, t0if_set_en, intf_set_en, rbif_set_en;
  logic int_stack_push, int_pc_load, int_busy, sleep_wake;
  logic [PC_WIDTH-1:0] int_vector;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef CORE_INT_RB_CHANGE_EN
  localparam logic RB_EN = 1'b1;
`else
  localparam logic RB_EN = 1'b0;
`endif

  core_interrupt_controller #(.PC_WIDTH(PC_WIDTH), .VECTOR_ADDR(13'h004)) dut (
    .clk(clk), .rst(rst),
    .intcon_gie(gie), .intcon_peie(peie), .intcon_t0ie(t0ie),
    .intcon_inte(inte), .intcon_rbie(rbie),
    .intcon_t0if(t0if), .intcon_intf(intf), .intcon_rbif(rbif),
    .tmr0_overflow(tmr0_overflow), .rb0_pin(rb0_pin),
    .option_intedg(option_intedg), .rb_port_hi(rb_port_hi),
    .rb_port_read(rb_port_read), .instr_boundary(instr_boundary),
    .retfie_exec(retfie_exec),
    .intcon_gie_clr_en(gie_clr_en), .intcon_gie_set_en(gie_set_en),
    .intcon_t0if_set_en(t0if_set_en), .intcon_intf_set_en(intf_set_en),
    .intcon_rbif_set_en(rbif_set_en),
    .int_stack_push(int_stack_push), .int_pc_load(int_pc_load),
    .int_vector(int_vector), .int_busy(int_busy), .sleep_wake(sleep_wake)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; pulse inputs drop back to 0
  task automatic tick();
    @(posedge clk);
    #1;
    tmr0_overflow  = 1'b0;
    rb_port_read   = 1'b0;
    instr_boundary = 1'b0;
    retfie_exec    = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_push"},  16'(int_stack_push), 16'h0);
    chk({tag, "_load"},  16'(int_pc_load),    16'h0);
    chk({tag, "_clr"},   16'(gie_clr_en),     16'h0);
    chk({tag, "_busy"},  16'(int_busy),       16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {gie, peie, t0ie, inte, rbie, t0if, intf, rbif} = '0;
    tmr0_overflow = 1'b0; rb0_pin = 1'b0; rb_port_hi = 4'h0;
    rb_port_read = 1'b0; instr_boundary = 1'b0; retfie_exec = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_sleep", 16'(sleep_wake),  16'h0);
    chk("rst_rbif",  16'(rbif_set_en), 16'h0);
    chk("rst_intf",  16'(intf_set_en), 16'h0);
    tick();
    rst = 1'b0;
  endtask

  // Randomized event stream with GIE off; expectations come from pin histories.
  task automatic run_random(input logic edge_sel);
    logic       pin_h [0:NRAND+3];
    logic [3:0] port_h[0:NRAND+3];
    logic [3:0] latch_m;
    logic       e_intf, e_rbif, e_sleep, a, b;
    for (int k = 0; k < NRAND + 4; k++) begin
      pin_h[k]  = 1'b0;
      port_h[k] = 4'h0;
    end
    latch_m = 4'h0;
    option_intedg = edge_sel;
    do_reset();
    for (int i = 0; i < NRAND; i++) begin
      pin_h[i+4]  = 1'($urandom_range(0, 1));
      port_h[i+4] = 4'($urandom_range(0, 15));
      rb0_pin       = pin_h[i+4];
      rb_port_hi    = port_h[i+4];
      tmr0_overflow = 1'($urandom_range(0, 1));
      retfie_exec   = 1'($urandom_range(0, 1));
      rb_port_read  = ($urandom_range(0, 3) == 0);
      {t0ie, inte, rbie, t0if, intf, rbif} = 6'($urandom_range(0, 63));
      gie = 1'b0;
      @(negedge clk);
      // Pin seen in cycle i reaches the edge strobe in cycle i+3
      a = pin_h[i+1];
      b = pin_h[i];
      e_intf  = edge_sel ? (a && !b) : (!a && b);
      e_rbif  = RB_EN && (port_h[i+2] != latch_m);
      e_sleep = (t0ie && t0if) || (inte && intf) || (RB_EN && rbie && rbif);
      chk("rnd_t0if",  16'(t0if_set_en), 16'(tmr0_overflow));
      chk("rnd_gieset", 16'(gie_set_en), 16'(retfie_exec));
      chk("rnd_intf",  16'(intf_set_en), 16'(e_intf));
      chk("rnd_rbif",  16'(rbif_set_en), 16'(e_rbif));
      chk("rnd_sleep", 16'(sleep_wake),  16'(e_sleep));
      chk("rnd_busy",  16'(int_busy),    16'h0);
      if (rb_port_read) latch_m = port_h[i+2];
      tick();
    end
  endtask

  initial begin
    option_intedg = 1'b1;
    do_reset();

    // Reset state after release
    @(negedge clk);
    chk_quiet("post_rst");
    chk("vector_const", 16'(int_vector), 16'h0004);
    tick();

    // TMR0 overflow strobe, then a normal entry with RETFIE coinciding in PUSH
    gie = 1'b1; t0ie = 1'b1; tmr0_overflow = 1'b1;
    @(negedge clk);
    chk("t0_strobe", 16'(t0if_set_en), 16'h1);
    chk("t0_busy0",  16'(int_busy),    16'h0);
    tick();
    t0if = 1'b1;
    @(negedge clk);
    chk("t0_strobe_off", 16'(t0if_set_en), 16'h0);
    chk("a_idle",        16'(int_busy),    16'h0);
    tick();
    instr_boundary = 1'b1;
    @(negedge clk);
    chk("a_pend_busy", 16'(int_busy),       16'h1);
    chk("a_pend_push", 16'(int_stack_push), 16'h0);
    tick();
    retfie_exec = 1'b1;
    @(negedge clk);
    chk("a_push",     16'(int_stack_push), 16'h1);
    chk("a_clr",      16'(gie_clr_en),     16'h1);
    chk("a_set_also", 16'(gie_set_en),     16'h1);
    chk("a_noload",   16'(int_pc_load),    16'h0);
    tick();
    gie = 1'b0;
    @(negedge clk);
    chk("a_load",   16'(int_pc_load),    16'h1);
    chk("a_vector", 16'(int_vector),     16'h0004);
    chk("a_nopush", 16'(int_stack_push), 16'h0);
    tick();
    t0if = 1'b0;
    @(negedge clk);
    chk_quiet("a_done");
    tick();

    // Minimum entry: boundary in the rising cycle is ignored, load 3 cycles on
    gie = 1'b1; t0if = 1'b1; instr_boundary = 1'b1;
    @(negedge clk);
    chk("m_c0_busy", 16'(int_busy), 16'h0);
    tick();
    instr_boundary = 1'b1;
    @(negedge clk);
    chk("m_c1_busy", 16'(int_busy), 16'h1);
    tick();
    @(negedge clk);
    chk("m_c2_push", 16'(int_stack_push), 16'h1);
    tick();
    gie = 1'b0;
    @(negedge clk);
    chk("m_c3_load", 16'(int_pc_load), 16'h1);
    tick();
    t0if = 1'b0; t0ie = 1'b0;
    tick();

    // RB0 rising edge with GIE off: strobe 3 cycles later, wake but no entry
    inte = 1'b1; option_intedg = 1'b1; rb0_pin = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("int_edge_c%0d", c), 16'(intf_set_en), (c == 3) ? 16'h1 : 16'h0);
      tick();
    end
    intf = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("int_sleep", 16'(sleep_wake), 16'h1);
      chk("int_busy",  16'(int_busy),   16'h0);
      tick();
    end
    intf = 1'b0; inte = 1'b0; rb0_pin = 1'b0;
    repeat (5) tick();

    // Pending withdrawn by software before the boundary
    gie = 1'b1; t0ie = 1'b1; t0if = 1'b1;
    tick();
    gie = 1'b0;
    @(negedge clk);
    chk("w_pend", 16'(int_busy), 16'h1);
    tick();
    instr_boundary = 1'b1;
    @(negedge clk);
    chk_quiet("w_idle");
    tick();
    @(negedge clk);
    chk_quiet("w_after");
    tick();

    // RETFIE in IDLE re-enables GIE; PENDING two cycles after the pulse
    retfie_exec = 1'b1;
    @(negedge clk);
    chk("r_set",  16'(gie_set_en), 16'h1);
    chk("r_busy", 16'(int_busy),   16'h0);
    tick();
    gie = 1'b1;
    @(negedge clk);
    chk("r_set_off", 16'(gie_set_en), 16'h0);
    chk("r_busy1",   16'(int_busy),   16'h0);
    tick();
    gie = 1'b0;
    @(negedge clk);
    chk("r_pending", 16'(int_busy), 16'h1);
    tick();
    @(negedge clk);
    chk("r_back_idle", 16'(int_busy), 16'h0);
    tick();
    t0if = 1'b0; t0ie = 1'b0;
    tick();

    // RB change: continuous strobe until a PORTB read
    rb_port_hi = 4'hA;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) rb_port_read = 1'b1;
      @(negedge clk);
      chk($sformatf("rb_c%0d", c), 16'(rbif_set_en),
          (RB_EN && c >= 2 && c <= 5) ? 16'h1 : 16'h0);
      tick();
    end

    // Reset landing in PUSH suppresses push and load
    gie = 1'b1; t0ie = 1'b1; t0if = 1'b1;
    tick();
    instr_boundary = 1'b1;
    @(negedge clk);
    chk("x_pend", 16'(int_busy), 16'h1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("x_rst_push", 16'(int_stack_push), 16'h0);
    chk("x_rst_clr",  16'(gie_clr_en),     16'h0);
    tick();
    rst = 1'b0; t0if = 1'b0;
    @(negedge clk);
    chk_quiet("x_idle");
    chk("x_sleep", 16'(sleep_wake), 16'h0);
    tick();
    @(negedge clk);
    chk("x_noload", 16'(int_pc_load), 16'h0);
    tick();

    run_random(1'b1);
    run_random(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/core_interrupt_controller.md
# core_interrupt_controller

Sequences interrupt entry and exit for the PIC16F core around the INTCON register. Detects external RB0/INT edges, RB7:4 port changes and TMR0 overflow, and raises the matching flag-set strobes into the INTCON register. Decides when an enabled, flagged interrupt is taken at an instruction boundary, and drives the core's stack-push, PC-vector load and GIE clear/set strobes. Sits between the INTCON register, TMR0, PORTB and the core fetch/execute control.

## Interface
- PC_WIDTH, 13, program counter width
- VECTOR_ADDR, 13'h004, interrupt vector loaded into PC
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- intcon_gie, intcon_peie, intcon_t0ie, intcon_inte, intcon_rbie  in  1 each  enable bits from INTCON
- intcon_t0if, intcon_intf, intcon_rbif  in  1 each  flag bits from INTCON
- tmr0_overflow  in  1  one-cycle pulse on TMR0 FFh→00h wrap
- rb0_pin  in  1  asynchronous RB0/INT pin
- option_intedg  in  1  1 = rising edge, 0 = falling edge on RB0/INT
- rb_port_hi  in  4  asynchronous RB7:4 pins
- rb_port_read  in  1  pulse: core executed a read of PORTB
- instr_boundary  in  1  pulse: current instruction finished, next fetch not yet committed
- retfie_exec  in  1  pulse: RETFIE executing
- intcon_gie_clr_en, intcon_gie_set_en  out  1  GIE strobes to INTCON
- intcon_t0if_set_en, intcon_intf_set_en, intcon_rbif_set_en  out  1  flag-set strobes to INTCON
- int_stack_push  out  1  push current PC onto hardware stack
- int_pc_load  out  1  load PC from int_vector
- int_vector  out  PC_WIDTH  constant VECTOR_ADDR
- int_busy  out  1  high in PENDING/PUSH/VECTOR; core stalls fetch
- sleep_wake  out  1  any (flag & enable) pair set, independent of GIE

## Operation
- Synchronisers: rb0_pin and rb_port_hi pass through two flops each. The edge detector compares the second stage with a third history flop.
- INT edge: synced rising edge (intedg=1) or falling edge (intedg=0) → intcon_intf_set_en for 1 cycle.
- TMR0: tmr0_overflow → intcon_t0if_set_en the same cycle, combinationally.
- RB change: rb_latch (4 bits) loads the synced port on rb_port_read. intcon_rbif_set_en is high on every cycle where synced port ≠ rb_latch.
- pending = gie & ((t0ie & t0if) | (inte & intf) | (rbie & rbif)). peie is passed through unused; it is reserved for peripheral sources.
- FSM states are IDLE, PENDING, PUSH and VECTOR:
  - IDLE → PENDING when pending=1.
  - PENDING → PUSH on instr_boundary. If pending drops first (GIE or enable cleared by software), return to IDLE.
  - PUSH: int_stack_push=1 and intcon_gie_clr_en=1 for one cycle, then → VECTOR.
  - VECTOR: int_pc_load=1 for one cycle, then → IDLE.
- RETFIE: retfie_exec pulses intcon_gie_set_en in the same cycle in any state. It has no other effect on the FSM.
- Flags are never cleared by this block; software clears them through INTCON writes.

## Timing
- Reset: FSM=IDLE, rb_latch=0, sync/history flops=0. All strobes, int_busy and sleep_wake are 0. int_vector is constant.
- Event → flag-set strobe latency:
  - tmr0_overflow: 0 cycles.
  - RB0 edge: 3 cycles after the pin change.
  - RB change: 2 cycles after the pin change.
- pending → PENDING: 1 cycle. PENDING + instr_boundary → PUSH: 1 cycle. PUSH → VECTOR: 1 cycle.
- Minimum entry, from pending rising at a boundary cycle to the int_pc_load pulse: 3 cycles.
- instr_boundary seen in IDLE in the same cycle pending rises is not used. Entry waits for the next boundary.
- retfie_exec and intcon_gie_clr_en in the same cycle (RETFIE in PUSH): clr takes priority in INTCON. This block still drives both strobes.
- rb_port_read in the same cycle as a port change: the latch takes the new synced value, and rbif_set_en is suppressed from the following cycle.
- A rst pulse in any state returns to IDLE with no push or load issued in that cycle.

## Configuration
- CORE_INT_RB_CHANGE_EN defined: RB7:4 synchronisers, rb_latch and rbif_set_en logic are built, and rbie & rbif contribute to pending and sleep_wake.
- CORE_INT_RB_CHANGE_EN undefined: intcon_rbif_set_en is tied 0, rb_port_hi and rb_port_read are ignored, and the rbie/rbif term is removed from pending and sleep_wake.

## Test plan
- gie=1, t0ie=1; tmr0_overflow pulse → t0if_set_en same cycle. Drive t0if=1 next cycle, then instr_boundary → int_stack_push and gie_clr_en 1 cycle later, int_pc_load with int_vector=0x004 the next cycle.
- intedg=1, inte=1, gie=0; rb0_pin 0→1 → intf_set_en after 3 cycles. With intf=1: sleep_wake=1, FSM stays IDLE, int_busy=0.
- PENDING entered; software clears gie before instr_boundary → return to IDLE, no push or load.
- retfie_exec pulse in IDLE → gie_set_en=1 for exactly that cycle. With t0if=t0ie=1, re-entry reaches PENDING 2 cycles after the pulse (gie_set_en edge, then gie high, then PENDING registered).
- rb_port_hi 0x0→0xA, no read → rbif_set_en continuous. rb_port_read → deasserts 1 cycle later. Undefined macro → stays 0 throughout.
- rst asserted during PUSH → next cycle IDLE, all outputs 0, no int_pc_load.
